// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of one synchronous single-port RAM.
// At most one access is granted per cycle. The last-grant pointer is registered.
// Read data, which returns one cycle later, is steered back to the master that issued the read.
// Optional build macro MEM_ARB_LOCK_EN adds m0_lock/m1_lock. With it, the last-granted
// master can keep ownership for as long as it requests with lock set.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_INIT    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef MEM_ARB_LOCK_EN
  input  logic                    m0_lock,
  input  logic                    m1_lock,
`endif
  input  logic                    m0_req,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic                    m0_ready,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic                    m1_ready,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wenable,
  output logic                    mem_ren,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int   STRB_WIDTH = DATA_WIDTH / 8;
  // The pointer resets to the opposite of RR_INIT, so RR_INIT wins the first tie.
  localparam logic LAST_INIT  = (RR_INIT == 0) ? 1'b1 : 1'b0;

  // Master-indexed views of the two request ports
  logic [1:0]            req_vec;
  logic [ADDR_WIDTH-1:0] addr_vec  [2];
  logic [DATA_WIDTH-1:0] wdata_vec [2];
  logic [STRB_WIDTH-1:0] wstrb_vec [2];
  logic [1:0]            rvalid_vec;
  logic [DATA_WIDTH-1:0] rdata_vec [2];

  assign req_vec      = {m1_req, m0_req};
  assign addr_vec[0]  = m0_addr;
  assign addr_vec[1]  = m1_addr;
  assign wdata_vec[0] = m0_wdata;
  assign wdata_vec[1] = m1_wdata;
  assign wstrb_vec[0] = m0_wstrb;
  assign wstrb_vec[1] = m1_wstrb;

  logic                  last_grant_reg, last_grant_next;
  logic                  resp_pending_reg, resp_pending_next;
  logic                  resp_owner_reg, resp_owner_next;
  logic [ADDR_WIDTH-1:0] addr_hold_reg, addr_hold_next;
  logic [DATA_WIDTH-1:0] wdata_hold_reg, wdata_hold_next;

  logic                  grant_valid;
  logic                  winner;
  logic                  is_read;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [STRB_WIDTH-1:0] win_wstrb;

  // Pick the winner. A lone requester always wins; on a tie the master that was not granted last wins.
  always_comb begin
    // Nothing is granted while reset is held, so all ready outputs read 0 during reset.
    grant_valid = rst_n && (req_vec != 2'b00);
    winner      = 1'b0;
    if (req_vec == 2'b11) begin
      winner = ~last_grant_reg;
    end else if (req_vec == 2'b10) begin
      winner = 1'b1;
    end
`ifdef MEM_ARB_LOCK_EN
    // A locked, requesting last owner keeps the port and overrides round-robin.
    if (!last_grant_reg && m0_req && m0_lock) begin
      winner = 1'b0;
    end else if (last_grant_reg && m1_req && m1_lock) begin
      winner = 1'b1;
    end
`endif
  end

  // Steer the winner onto the memory port. When nothing is granted, addr/wdata hold their last values.
  always_comb begin
    win_addr    = addr_vec[winner];
    win_wdata   = wdata_vec[winner];
    win_wstrb   = wstrb_vec[winner];
    is_read     = grant_valid && (win_wstrb == '0);
    m0_ready    = grant_valid && !winner;
    m1_ready    = grant_valid && winner;
    mem_addr    = grant_valid ? win_addr  : addr_hold_reg;
    mem_wdata   = grant_valid ? win_wdata : wdata_hold_reg;
    mem_wenable = grant_valid ? win_wstrb : '0;
    mem_ren     = is_read;
  end

  // Next-state values for the pointer, the response tracker and the held memory address/data.
  always_comb begin
    last_grant_next   = last_grant_reg;
    addr_hold_next    = addr_hold_reg;
    wdata_hold_next   = wdata_hold_reg;
    resp_pending_next = is_read;
    resp_owner_next   = resp_owner_reg;
    if (grant_valid) begin
      last_grant_next = winner;
      addr_hold_next  = win_addr;
      wdata_hold_next = win_wdata;
    end
    if (is_read) begin
      resp_owner_next = winner;
    end
  end

  // State registers. Asynchronous reset drops any in-flight response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg   <= LAST_INIT;
      resp_pending_reg <= 1'b0;
      resp_owner_reg   <= 1'b0;
      addr_hold_reg    <= '0;
      wdata_hold_reg   <= '0;
    end else begin
      last_grant_reg   <= last_grant_next;
      resp_pending_reg <= resp_pending_next;
      resp_owner_reg   <= resp_owner_next;
      addr_hold_reg    <= addr_hold_next;
      wdata_hold_reg   <= wdata_hold_next;
    end
  end

  // Return read data only to the owner of the outstanding read. Everyone else sees zeros.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign rvalid_vec[gi] = resp_pending_reg && (resp_owner_reg == 1'(gi));
    assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : '0;
  end

  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = rdata_vec[0];
  assign m1_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// A behavioural model predicts each cycle's grant and each read's returned word.
// A negedge monitor pops those predictions and compares them with the DUT.
// Build with MEM_ARB_LOCK_EN defined to also exercise the lock inputs.
module tb_mem_port_arbiter;

  localparam int RR_INIT = 0;
`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, mem_ren;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model, 16 words. Outside a read it drives garbage so that rdata gating is visible.
  logic [31:0] tb_mem [16];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= tb_mem[mem_addr[5:2]];
    else         mem_rdata <= $urandom;
    for (int b = 0; b < 4; b++)
      if (mem_wenable[b]) tb_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  typedef struct {
    bit          gv;
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } grant_t;
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  grant_t gq[$];
  rsp_t   rq0[$];
  rsp_t   rq1[$];

  // Reference-model state
  logic [31:0] sh_mem [16];
  bit          m_last;
  logic [31:0] m_last_addr, m_last_wdata;
  bit          m_gv, m_win;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last       = (RR_INIT == 0);
    m_last_addr  = '0;
    m_last_wdata = '0;
    rq0.delete();
    rq1.delete();
  endtask

  // Apply one cycle of stimulus at posedge+1, queue the predicted outcome, then advance one cycle.
  task automatic drive_cycle(input bit r0, input logic [31:0] a0, input logic [31:0] d0,
                             input logic [3:0] s0, input bit l0,
                             input bit r1, input logic [31:0] a1, input logic [31:0] d1,
                             input logic [3:0] s1, input bit l1);
    grant_t g;
    rsp_t   r;
    bit     w;
    m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0; m0_lock = l0;
    m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1; m1_lock = l1;
    // Rules: a lone requester wins; on a tie the master not served last wins.
    // With lock support, a locked last owner that is still requesting keeps the port.
    if (r0 && !r1)      w = 1'b0;
    else if (r1 && !r0) w = 1'b1;
    else                w = !m_last;
    if (LOCK_EN && r0 && r1) begin
      if (!m_last && l0)     w = 1'b0;
      else if (m_last && l1) w = 1'b1;
    end
    g.gv = r0 || r1;
    g.w  = w;
    if (g.gv) begin
      m_last       = w;
      m_last_addr  = w ? a1 : a0;
      m_last_wdata = w ? d1 : d0;
    end
    g.addr  = m_last_addr;
    g.wdata = m_last_wdata;
    g.strb  = g.gv ? (w ? s1 : s0) : 4'h0;
    gq.push_back(g);
    if (g.gv) begin
      if (g.strb == 4'h0) begin
        r.data = sh_mem[g.addr[5:2]];
        r.due  = cyc + 1;
        if (w) rq1.push_back(r);
        else   rq0.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++)
          if (g.strb[b]) sh_mem[g.addr[5:2]][8*b +: 8] = g.wdata[8*b +: 8];
      end
    end
    m_gv  = g.gv;
    m_win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic mon_rsp(input int n, input logic rv, input logic [31:0] rd);
    rsp_t r;
    bit   have;
    have = (n == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
    if (have) r = (n == 0) ? rq0[0] : rq1[0];
    if (rv) begin
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL m%0d_rvalid_unexpected at cycle %0d: got 1 expected 0", n, cyc);
      end else begin
        if (n == 0) void'(rq0.pop_front());
        else        void'(rq1.pop_front());
        check($sformatf("m%0d_rdata", n), rd, r.data);
        check($sformatf("m%0d_rsp_cycle", n), cyc, r.due);
        $display("rsp m%0d data %08h cycle %0d", n, rd, cyc);
      end
    end else begin
      check($sformatf("m%0d_rdata_idle", n), rd, 32'h0);
      if (have && r.due <= cyc) begin
        if (n == 0) void'(rq0.pop_front());
        else        void'(rq1.pop_front());
        check($sformatf("m%0d_rvalid_missing", n), rv, 1'b1);
      end
    end
  endtask

  // Monitor: compares grant predictions and read responses on every cycle outside reset.
  always @(negedge clk) begin
    grant_t g;
    if (rst_n) begin
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_q_empty at cycle %0d: got none expected one", cyc);
      end else begin
        g = gq.pop_front();
        check("m0_ready", m0_ready, g.gv && !g.w);
        check("m1_ready", m1_ready, g.gv && g.w);
        check("mem_ren", mem_ren, g.gv && (g.strb == 4'h0));
        check("mem_wenable", mem_wenable, g.strb);
        check("mem_addr", mem_addr, g.addr);
        check("mem_wdata", mem_wdata, g.wdata);
      end
      mon_rsp(0, m0_rvalid, m0_rdata);
      mon_rsp(1, m1_rvalid, m1_rdata);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0_ready"}, m0_ready, 1'b0);
    check({tag, "_m1_ready"}, m1_ready, 1'b0);
    check({tag, "_m0_rvalid"}, m0_rvalid, 1'b0);
    check({tag, "_m1_rvalid"}, m1_rvalid, 1'b0);
    check({tag, "_mem_ren"}, mem_ren, 1'b0);
    check({tag, "_mem_wenable"}, mem_wenable, 4'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  bit          p0, p1;
  logic [31:0] a0, a1, d0, d1;
  logic [3:0]  s0, s1;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = $urandom;
      sh_mem[i] = tb_mem[i];
    end
    tb_mem[4] = 32'hDEADBEEF;
    sh_mem[4] = 32'hDEADBEEF;
    model_reset();

    // Requests asserted during reset must not be granted.
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single read from m0 at address 0x10
    drive_cycle(1, 32'h10, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    drive_cycle(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    // Byte write from m1
    drive_cycle(0, 0, 0, 4'h0, 0, 1, 32'h20, 32'h0000AB00, 4'b0010, 0);
    drive_cycle(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    // m0 read makes m0 the last grantee; then a tie goes to m1, and m0 is served the next cycle.
    drive_cycle(1, 32'h20, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    drive_cycle(1, 32'h08, 0, 4'h0, 0, 1, 32'h0C, 32'h12345678, 4'hF, 0);
    drive_cycle(1, 32'h08, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    drive_cycle(1, 32'h0C, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    // Contention: both masters read on every cycle
    for (int i = 0; i < 6; i++)
      drive_cycle(1, 32'(i * 4), 0, 4'h0, 0, 1, 32'(60 - i * 4), 0, 4'h0, 0);
    // Lock: m0 keeps the port for 4 cycles, then m1 gets it once the lock is released.
    if (LOCK_EN) begin
      for (int i = 0; i < 4; i++)
        drive_cycle(1, 32'h10, 0, 4'h0, 1, 1, 32'h14, 0, 4'h0, 0);
      drive_cycle(1, 32'h10, 0, 4'h0, 0, 1, 32'h14, 0, 4'h0, 0);
    end

    // Reset asserted while a read response is in flight
    drive_cycle(1, 32'h10, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    check("pre_reset_m0_rvalid", m0_rvalid, 1'b1);
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // The first tie after reset goes to RR_INIT.
    drive_cycle(1, 32'h04, 0, 4'h0, 0, 1, 32'h08, 0, 4'h0, 0);
    drive_cycle(1, 32'h04, 0, 4'h0, 0, 1, 32'h08, 0, 4'h0, 0);

    // Randomized traffic. Requests are held until accepted, and occasionally withdrawn.
    p0 = 0; p1 = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0) begin
        p0 = ($urandom_range(0, 2) != 0);
        a0 = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d0 = $urandom;
        s0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        p0 = 0;
      end
      if (!p1) begin
        p1 = ($urandom_range(0, 2) != 0);
        a1 = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d1 = $urandom;
        s1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        p1 = 0;
      end
      drive_cycle(p0, a0, d0, s0, ($urandom_range(0, 3) == 0),
                  p1, a1, d1, s1, ($urandom_range(0, 3) == 0));
      if (m_gv) begin
        if (m_win) p1 = 0;
        else       p0 = 0;
      end
    end

    // Drain any remaining responses.
    for (int i = 0; i < 3; i++)
      drive_cycle(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    check("rq0_drained", rq0.size(), 0);
    check("rq1_drained", rq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port memory between two requesters: m0, the CPU data/instruction port, and m1, a debug/DMA loader.
- Grants at most one access per cycle, using round-robin priority with a registered last-grant pointer.
- Routes the one-cycle-latency read data back to the master whose read was granted.
- Sits between the core and the unified RAM in the SoC top.

Parameters:
- ADDR_WIDTH, 32, address width of each master and of the memory.
- DATA_WIDTH, 32, data width; DATA_WIDTH/8 byte strobes.
- RR_INIT, 0, master that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request. Addr/wdata/wstrb are held stable until accepted.
- m0_addr  in  ADDR_WIDTH  master 0 byte address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_wstrb  in  DATA_WIDTH/8  master 0 byte write enables. 0 = read.
- m0_ready  out  1  master 0 request accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_WIDTH  master 0 read data.
- m1_req, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rvalid, m1_rdata: identical to the master 0 ports, for master 1.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wenable  out  DATA_WIDTH/8  memory byte write enables.
- mem_ren  out  1  memory read strobe.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_ren.

Behaviour:
- Reset: last_grant = ~RR_INIT; resp_pending = 0; resp_owner = 0.
- Reset: all ready/rvalid outputs are 0; mem_wenable = 0; mem_ren = 0; mem_addr and mem_wdata are 0.
- Arbitration (combinational on req, registered pointer):
  - Only one master requesting: that master wins.
  - Both requesting: the master != last_grant wins.
  - Neither requesting: no grant.
- Grant drives winner's addr/wdata/wstrb onto mem_*.
  - Winner's ready = 1 in the same cycle.
  - Loser's ready = 0.
- No grant: mem_wenable = 0, mem_ren = 0. mem_addr and mem_wdata hold their last values; they are don't-care for the memory.
- Write: mem_wenable = winner's wstrb when wstrb != 0; mem_ren = 0; no response is generated.
- Read: wstrb == 0 gives mem_ren = 1 and mem_wenable = 0.
- On clk edge after any grant: last_grant <= winner.
- On clk edge after a read grant: resp_pending <= 1 and resp_owner <= winner. Otherwise resp_pending <= 0.
- Read latency is exactly 1 cycle after ready.
  - mN_rvalid = resp_pending && resp_owner == N.
  - mN_rdata = mem_rdata when rvalid is set, else 0.
- Back-to-back reads from alternating masters are fully pipelined:
  - response N and grant N+1 occur in the same cycle;
  - sustained throughput is one access per cycle.
- Fairness: a continuously requesting master is granted within 2 cycles of raising req.
- A master dropping req before ready is legal; nothing is issued for that request.
- Reset asserted mid-operation: the pending read response is discarded (rvalid forced 0 immediately, asynchronously) and the pointer is reinitialised.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined, adds inputs m0_lock and m1_lock (1 bit each).
- If the last granted master requests with its lock = 1, it wins regardless of round-robin, and the other master waits.
- Lock is ignored while that master is not requesting.
- When undefined, the lock ports do not exist and arbitration is pure round-robin.

Test Plan:
- Single read: m0_req, addr 0x10, wstrb 0, mem returns 0xDEADBEEF → m0_ready in cycle 0; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF in cycle 1; m1_rvalid stays 0.
- Contention: both req reads every cycle from reset with RR_INIT = 0 → grants alternate m0, m1, m0, m1; each rvalid lands 1 cycle after the matching ready.
- Byte write: m1 writes wstrb 4'b0010, wdata 0x0000AB00, addr 0x20 → mem_wenable = 0010, mem_ren = 0; no rvalid on the next cycle.
- Mixed: m0 read and m1 write together, last_grant = 0 → m1 granted first; m0 granted the next cycle; m0_rvalid arrives 2 cycles after req.
- Reset: assert rst_n low the cycle after a read grant → m0_rvalid is 0 immediately, all outputs return to reset values, and the first tie after release goes to RR_INIT.
- Lock (MEM_ARB_LOCK_EN defined): m0 holds lock = 1 with req for 4 cycles while m1 requests → m0 is granted 4 times consecutively, then m1 is granted the cycle after m0's lock drops.
